// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: two-stage scale/saturate pipeline, pending register and 64-bclk I2S framer.
// Define I2S_SER_ROUND_EN to round (half up) in stage 1 instead of truncating.
module i2s_dac_serializer #(
   parameter int DATA_SHIFT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        din_valid,
   input  logic [33:0] l_data_in,
   input  logic [33:0] r_data_in,
   output logic        bclk,
   output logic        lrck,
   output logic        sdata,
   output logic        underrun,
   output logic        overrun,
   output logic        clip,
   output logic        sample_pending
);

   localparam logic signed [34:0] SAT_MAX = 35'sd8388607;
   localparam logic signed [34:0] SAT_MIN = -35'sd8388608;
`ifdef I2S_SER_ROUND_EN
   localparam logic signed [34:0] ROUND_BIAS = 35'sd1 <<< (DATA_SHIFT - 1);
`endif

   logic signed [34:0] ext_l, ext_r;
   logic signed [34:0] s1_l_q, s1_r_q, s1_l_d, s1_r_d;
   logic               s1_valid_q;
   logic [23:0]        pend_l_q, pend_r_q, pend_l_d, pend_r_d;
   logic               pend_q, pend_d;
   logic [23:0]        act_l_q, act_r_q, act_l_d, act_r_d;
   logic [2:0]         div_q, div_d;
   logic [5:0]         bit_q, bit_d;
   logic               sdata_q, sdata_d;
   logic               underrun_q, underrun_d;
   logic               overrun_q, overrun_d;
   logic               clip_q, clip_d;
   logic [23:0]        sat_l, sat_r;
   logic               clip_l, clip_r;
   logic               load;
   logic [5:0]         bit_nxt;
   logic [4:0]         slot_k;
   logic [23:0]        slot_word;

   // Stage 1: 35-bit sign extension leaves headroom for the rounding bias.
   always_comb begin
      ext_l = {l_data_in[33], l_data_in};
      ext_r = {r_data_in[33], r_data_in};
`ifdef I2S_SER_ROUND_EN
      ext_l = ext_l + ROUND_BIAS;
      ext_r = ext_r + ROUND_BIAS;
`endif
      s1_l_d = din_valid ? (ext_l >>> DATA_SHIFT) : s1_l_q;
      s1_r_d = din_valid ? (ext_r >>> DATA_SHIFT) : s1_r_q;
   end

   always_comb begin
      clip_l = (s1_l_q > SAT_MAX) || (s1_l_q < SAT_MIN);
      clip_r = (s1_r_q > SAT_MAX) || (s1_r_q < SAT_MIN);
      sat_l  = (s1_l_q > SAT_MAX) ? 24'h7FFFFF : (s1_l_q < SAT_MIN) ? 24'h800000 : s1_l_q[23:0];
      sat_r  = (s1_r_q > SAT_MAX) ? 24'h7FFFFF : (s1_r_q < SAT_MIN) ? 24'h800000 : s1_r_q[23:0];
   end

   // A stage-2 write landing on the load edge bypasses the pending register.
   always_comb begin
      pend_l_d   = pend_l_q;
      pend_r_d   = pend_r_q;
      pend_d     = pend_q;
      act_l_d    = act_l_q;
      act_r_d    = act_r_q;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
      clip_d     = s1_valid_q && (clip_l || clip_r);
      load       = run && (bit_q == 6'd63) && (div_q == 3'd7);
      if (load) begin
         pend_d = 1'b0;
         if (s1_valid_q) begin
            act_l_d = sat_l;
            act_r_d = sat_r;
         end else if (pend_q) begin
            act_l_d = pend_l_q;
            act_r_d = pend_r_q;
         end else begin
            underrun_d = 1'b1;
         end
      end else if (s1_valid_q) begin
         pend_l_d  = sat_l;
         pend_r_d  = sat_r;
         pend_d    = 1'b1;
         overrun_d = pend_q;
      end

      bit_nxt   = bit_q + 6'd1;
      slot_k    = bit_nxt[4:0];
      slot_word = bit_nxt[5] ? act_r_q : act_l_q;
      div_d     = div_q + 3'd1;
      bit_d     = bit_q;
      sdata_d   = sdata_q;
      if (div_q == 3'd7) begin
         bit_d   = bit_nxt;
         sdata_d = (slot_k >= 5'd1 && slot_k <= 5'd24) ? slot_word[5'd24 - slot_k] : 1'b0;
      end
      // Idle: framer parked at frame start and active words zeroed so the first frame is silent.
      if (!run) begin
         div_d   = 3'd0;
         bit_d   = 6'd0;
         sdata_d = 1'b0;
         act_l_d = 24'd0;
         act_r_d = 24'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_l_q     <= '0;
         s1_r_q     <= '0;
         s1_valid_q <= 1'b0;
         pend_l_q   <= '0;
         pend_r_q   <= '0;
         pend_q     <= 1'b0;
         act_l_q    <= '0;
         act_r_q    <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
         clip_q     <= 1'b0;
      end else begin
         s1_l_q     <= s1_l_d;
         s1_r_q     <= s1_r_d;
         s1_valid_q <= din_valid;
         pend_l_q   <= pend_l_d;
         pend_r_q   <= pend_r_d;
         pend_q     <= pend_d;
         act_l_q    <= act_l_d;
         act_r_q    <= act_r_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
         clip_q     <= clip_d;
      end
   end

   assign bclk           = div_q[2];
   assign lrck           = bit_q[5];
   assign sdata          = sdata_q;
   assign underrun       = underrun_q;
   assign overrun        = overrun_q;
   assign clip           = clip_q;
   assign sample_pending = pend_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Self-checking bench for i2s_dac_serializer: a serial receiver rebuilds each frame and a
// scoreboard queue of expected left/right words is compared frame by frame.
module tb_i2s_dac_serializer;

   localparam int DATA_SHIFT = 8;
`ifdef I2S_SER_ROUND_EN
   localparam logic [23:0] ROUND_EXP = 24'h000002;
`else
   localparam logic [23:0] ROUND_EXP = 24'h000001;
`endif

   typedef struct packed {
      logic [23:0] l;
      logic [23:0] r;
   } pair_t;

   logic        clk = 1'b0;
   logic        reset, run, din_valid;
   logic [33:0] l_data_in, r_data_in;
   logic        bclk, lrck, sdata, underrun, overrun, clip, sample_pending;

   int    checks = 0;
   int    errors = 0;
   pair_t exp_q[$];
   pair_t exp;

   i2s_dac_serializer #(.DATA_SHIFT(DATA_SHIFT)) dut (
      .clk(clk), .reset(reset), .run(run), .din_valid(din_valid),
      .l_data_in(l_data_in), .r_data_in(r_data_in),
      .bclk(bclk), .lrck(lrck), .sdata(sdata),
      .underrun(underrun), .overrun(overrun), .clip(clip),
      .sample_pending(sample_pending)
   );

   always #5 clk = ~clk;

   // Receiver: samples sdata on bclk rising edges, slot bit 0 follows each lrck change.
   int          cyc = 0;
   int          mon_k = 31;
   logic        last_lr = 1'b1;
   logic        prev_bclk = 1'b0, prev_lrck = 1'b0;
   logic [23:0] word = '0, cap_l = '0, cap_r = '0;
   logic        zviol = 1'b0, zv_l = 1'b0, zv_r = 1'b0;
   logic [4:0]  idx;
   int          frame_cnt = 0;
   int          last_brise = -1, last_lrise = -1;
   int          bclk_bad = 0, lrck_bad = 0, n_bper = 0, n_lper = 0;

   always @(negedge clk) begin
      cyc++;
      if (reset || !run) begin
         mon_k      = 31;
         last_lr    = 1'b1;
         prev_bclk  = 1'b0;
         prev_lrck  = 1'b0;
         last_brise = -1;
         last_lrise = -1;
      end else begin
         if (bclk && !prev_bclk) begin
            if (last_brise >= 0) begin
               n_bper++;
               if (cyc - last_brise != 8) bclk_bad++;
            end
            last_brise = cyc;
            if (lrck != last_lr) begin
               mon_k   = 0;
               last_lr = lrck;
               word    = '0;
               zviol   = 1'b0;
            end else begin
               mon_k++;
            end
            if (mon_k >= 1 && mon_k <= 24) begin
               idx       = 5'(24 - mon_k);
               word[idx] = sdata;
            end else if (sdata) begin
               zviol = 1'b1;
            end
            if (mon_k == 31) begin
               if (!lrck) begin
                  cap_l = word;
                  zv_l  = zviol;
               end else begin
                  cap_r = word;
                  zv_r  = zviol;
                  frame_cnt++;
               end
            end
         end
         if (lrck && !prev_lrck) begin
            if (last_lrise >= 0) begin
               n_lper++;
               if (cyc - last_lrise != 512) lrck_bad++;
            end
            last_lrise = cyc;
         end
         prev_bclk = bclk;
         prev_lrck = lrck;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_pair(input logic [33:0] l, input logic [33:0] r);
      l_data_in = l;
      r_data_in = r;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic await_frame();
      int start = frame_cnt;
      int n = 0;
      while (frame_cnt == start && n < 700) begin
         tick();
         n++;
      end
      checks++;
      if (frame_cnt == start) begin
         errors++;
         $display("[TB] FAIL frame_timeout: no frame completed in %0d clks, required <= 700", n);
      end
   endtask

   task automatic sync_frame();
      await_frame();
      repeat (8) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b0; din_valid = 1'b0;
      l_data_in = '0; r_data_in = '0;
      repeat (3) tick();
      checks++;
      if ({bclk, lrck, sdata} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_clocks: got %b, required 000", {bclk, lrck, sdata});
      end
      checks++;
      if ({underrun, overrun, clip, sample_pending} !== 4'b0000) begin
         errors++; $display("[TB] FAIL reset_status: got %b, required 0000", {underrun, overrun, clip, sample_pending});
      end
      reset = 1'b0;
      tick();
      run = 1'b1;
      exp_q.push_back('{l: 24'h0, r: 24'h0});
      await_frame();
      exp = exp_q.pop_front();
      checks++;
      if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
         errors++; $display("[TB] FAIL first_frame: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
      end
   endtask

   task automatic test_scaling();
      sync_frame();
      drive_pair(34'h000001200, 34'h3FFFFEE00);
      exp_q.push_back('{l: 24'h000012, r: 24'hFFFFEE});
      checks++;
      if (sample_pending !== 1'b0) begin
         errors++; $display("[TB] FAIL latency_early: sample_pending=%b one clk after din_valid, required 0", sample_pending);
      end
      tick();
      checks++;
      if ({sample_pending, clip} !== 2'b10) begin
         errors++; $display("[TB] FAIL latency_pending: {pending,clip}=%b, required 10", {sample_pending, clip});
      end
      await_frame();
      await_frame();
      exp = exp_q.pop_front();
      checks++;
      if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
         errors++; $display("[TB] FAIL scaling: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
      end
   endtask

   task automatic test_rounding();
      sync_frame();
      drive_pair(34'd384, 34'd0);
      exp_q.push_back('{l: ROUND_EXP, r: 24'h0});
      await_frame();
      await_frame();
      exp = exp_q.pop_front();
      checks++;
      if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
         errors++; $display("[TB] FAIL rounding: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
      end
   endtask

   task automatic test_saturation();
      int nclip = 0;
      sync_frame();
      drive_pair(34'h0FFFFFFFF, 34'h200000000);
      exp_q.push_back('{l: 24'h7FFFFF, r: 24'h800000});
      tick();
      checks++;
      if (clip !== 1'b1) begin
         errors++; $display("[TB] FAIL clip_timing: clip=%b at stage 2, required 1", clip);
      end
      for (int i = 0; i < 6; i++) begin
         if (clip) nclip++;
         tick();
      end
      checks++;
      if (nclip != 1) begin
         errors++; $display("[TB] FAIL clip_width: clip high %0d clks, required 1", nclip);
      end
      await_frame();
      await_frame();
      exp = exp_q.pop_front();
      checks++;
      if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
         errors++; $display("[TB] FAIL saturation: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
      end
   endtask

   task automatic test_overrun();
      int nov = 0;
      sync_frame();
      drive_pair(34'h000011100, 34'h000022200);
      repeat (10) begin
         tick();
         if (overrun) nov++;
      end
      drive_pair(34'h000033300, 34'h000044400);
      exp_q.push_back('{l: 24'h000333, r: 24'h000444});
      repeat (6) begin
         tick();
         if (overrun) nov++;
      end
      checks++;
      if (nov != 1) begin
         errors++; $display("[TB] FAIL overrun_count: overrun high %0d clks, required 1", nov);
      end
      await_frame();
      await_frame();
      exp = exp_q.pop_front();
      checks++;
      if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
         errors++; $display("[TB] FAIL overrun_data: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
      end
   endtask

   task automatic test_underrun();
      int nun = 0;
      repeat (8) begin
         tick();
         if (underrun) nun++;
      end
      checks++;
      if (nun != 1) begin
         errors++; $display("[TB] FAIL underrun_count: underrun high %0d clks, required 1", nun);
      end
      exp_q.push_back('{l: 24'h000333, r: 24'h000444});
      await_frame();
      exp = exp_q.pop_front();
      checks++;
      if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
         errors++; $display("[TB] FAIL underrun_repeat: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
      end
   endtask

   // Entered right after a frame completes: the load edge is four clks away.
   task automatic test_back_to_back();
      int nflag = 0;
      tick();
      tick();
      drive_pair(34'h000055500, 34'h000066600);
      exp_q.push_back('{l: 24'h000555, r: 24'h000666});
      tick();
      checks++;
      if (sample_pending !== 1'b0) begin
         errors++; $display("[TB] FAIL bypass_pending: sample_pending=%b after coincident load, required 0", sample_pending);
      end
      repeat (4) begin
         if (overrun || underrun) nflag++;
         tick();
      end
      checks++;
      if (nflag != 0) begin
         errors++; $display("[TB] FAIL bypass_flags: overrun/underrun high %0d clks, required 0", nflag);
      end
      await_frame();
      exp = exp_q.pop_front();
      checks++;
      if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
         errors++; $display("[TB] FAIL bypass_data: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
      end
   endtask

   task automatic test_timing();
      int b0 = bclk_bad, nb0 = n_bper, l0 = lrck_bad, nl0 = n_lper;
      for (int f = 0; f < 3; f++) begin
         await_frame();
         checks++;
         if ({zv_l, zv_r} !== 2'b00) begin
            errors++; $display("[TB] FAIL slot_zero_bits: frame %0d zv=%b%b, required 00", f, zv_l, zv_r);
         end
      end
      checks++;
      if (bclk_bad != b0 || n_bper - nb0 < 150) begin
         errors++; $display("[TB] FAIL bclk_period: %0d bad of %0d periods, required 0 bad of >=150", bclk_bad - b0, n_bper - nb0);
      end
      checks++;
      if (lrck_bad != l0 || n_lper - nl0 < 2) begin
         errors++; $display("[TB] FAIL lrck_period: %0d bad of %0d periods, required 0 bad of >=2", lrck_bad - l0, n_lper - nl0);
      end
   endtask

   task automatic test_run_low();
      logic active = 1'b0;
      tick();
      run = 1'b0;
      repeat (16) begin
         tick();
         if (bclk || lrck || sdata) active = 1'b1;
      end
      checks++;
      if (active !== 1'b0) begin
         errors++; $display("[TB] FAIL run_low_outputs: serial outputs toggled=%b, required 0", active);
      end
      drive_pair(34'h000ABCD00, 34'h3FF543300);
      tick();
      checks++;
      if (sample_pending !== 1'b1) begin
         errors++; $display("[TB] FAIL run_low_pipeline: sample_pending=%b, required 1", sample_pending);
      end
      run = 1'b1;
      exp_q.push_back('{l: 24'h0, r: 24'h0});
      exp_q.push_back('{l: 24'h00ABCD, r: 24'hFF5433});
      for (int f = 0; f < 2; f++) begin
         await_frame();
         exp = exp_q.pop_front();
         checks++;
         if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
            errors++; $display("[TB] FAIL run_start_frame%0d: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", f, cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int n = 0;
      sync_frame();
      drive_pair(34'h000077700, 34'h000088800);
      while (!(lrck && mon_k == 8) && n < 1200) begin
         tick();
         n++;
      end
      checks++;
      if (!(lrck && mon_k == 8)) begin
         errors++; $display("[TB] FAIL reach_bit40: lrck=%b k=%0d, required lrck=1 k=8", lrck, mon_k);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({bclk, lrck, sdata, underrun, overrun, clip, sample_pending} !== 7'b0) begin
         errors++; $display("[TB] FAIL reset_async: outputs=%b, required 0000000", {bclk, lrck, sdata, underrun, overrun, clip, sample_pending});
      end
      repeat (3) tick();
      reset = 1'b0;
      n = 0;
      while (!lrck && n < 600) begin
         tick();
         n++;
      end
      checks++;
      if (n != 256) begin
         errors++; $display("[TB] FAIL realign: lrck rose %0d clks after release, required 256", n);
      end
      exp_q.push_back('{l: 24'h0, r: 24'h0});
      exp_q.push_back('{l: 24'h0, r: 24'h0});
      for (int f = 0; f < 2; f++) begin
         await_frame();
         exp = exp_q.pop_front();
         checks++;
         if ({cap_l, cap_r, zv_l, zv_r} !== {exp.l, exp.r, 2'b00}) begin
            errors++; $display("[TB] FAIL post_reset_frame%0d: got L=%h R=%h zv=%b%b, required L=%h R=%h zv=00", f, cap_l, cap_r, zv_l, zv_r, exp.l, exp.r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scaling();
      test_rounding();
      test_saturation();
      test_overrun();
      test_underrun();
      test_back_to_back();
      test_timing();
      test_run_low();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
